// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues predicted BEQ/BNE records from decode, checks each against the
// EX outcome in order, trains the predictor and raises flush/redirect on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            pr_push,
  input  logic            pr_taken,
  input  logic [1:0]      pr_index,
  input  logic [31:0]     pr_target,
  input  logic [31:0]     pr_npc,
  input  logic            rs_valid,
  input  logic            rs_taken,
  output logic            full,
  output logic            upd_en,
  output logic [1:0]      upd_index,
  output logic            upd_taken,
  output logic            flush,
  output logic [31:0]     redirect_pc,
  output logic [CNTW-1:0] br_count,
  output logic [CNTW-1:0] mp_count,
  output logic            underflow
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
  endfunction

  ptr_t          rd_ptr_p0, wr_ptr_p0;
  ptr_t          rd_ptr_nxt, wr_ptr_nxt;
  logic [AW-1:0] rd_idx, wr_idx;

  logic          q_taken  [DEPTH];
  logic [1:0]    q_index  [DEPTH];
  logic [31:0]   q_target [DEPTH];
  logic [31:0]   q_npc    [DEPTH];

  logic          empty, is_full, pop, mispred, push_ok;

  logic            vld_p1;
  logic            flush_p1;
  logic [1:0]      index_p1;
  logic            taken_p1;
  logic [31:0]     redirect_p1;
  logic [CNTW-1:0] br_cnt_p1;
  logic [CNTW-1:0] mp_cnt_p1;
  logic            underflow_p1;

  // Stage p0: queue occupancy and resolve decision
  assign rd_idx  = rd_ptr_p0[AW-1:0];
  assign wr_idx  = wr_ptr_p0[AW-1:0];
  assign empty   = (rd_ptr_p0 == wr_ptr_p0);
  assign is_full = (rd_idx == wr_idx) && (rd_ptr_p0[AW] != wr_ptr_p0[AW]);

  assign pop     = rs_valid && !empty;
  assign mispred = pop && (rs_taken != q_taken[rd_idx]);
  // A push racing a mispredict is on the wrong path and is discarded
  assign push_ok = pr_push && (!is_full || pop) && !mispred;

  always_comb begin
    rd_ptr_nxt = rd_ptr_p0;
    wr_ptr_nxt = wr_ptr_p0;
    if (pop)
      rd_ptr_nxt = rd_ptr_p0 + ptr_t'(1);
    if (mispred)
      wr_ptr_nxt = rd_ptr_nxt;
    else if (push_ok)
      wr_ptr_nxt = wr_ptr_p0 + ptr_t'(1);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      q_taken[wr_idx]  <= pr_taken;
      q_index[wr_idx]  <= pr_index;
      q_target[wr_idx] <= pr_target;
      q_npc[wr_idx]    <= pr_npc;
    end
  end

  // Stage p1: registered training, redirect and statistics outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_p0    <= '0;
      wr_ptr_p0    <= '0;
      vld_p1       <= 1'b0;
      flush_p1     <= 1'b0;
      index_p1     <= '0;
      taken_p1     <= 1'b0;
      redirect_p1  <= '0;
      br_cnt_p1    <= '0;
      mp_cnt_p1    <= '0;
      underflow_p1 <= 1'b0;
    end else begin
      rd_ptr_p0 <= rd_ptr_nxt;
      wr_ptr_p0 <= wr_ptr_nxt;
      vld_p1    <= pop;
      flush_p1  <= mispred;
      if (pop) begin
        index_p1  <= q_index[rd_idx];
        taken_p1  <= rs_taken;
        br_cnt_p1 <= sat_inc(br_cnt_p1);
      end
      if (mispred) begin
        redirect_p1 <= rs_taken ? q_target[rd_idx] : q_npc[rd_idx];
        mp_cnt_p1   <= sat_inc(mp_cnt_p1);
      end
      if (rs_valid && empty)
        underflow_p1 <= 1'b1;
    end
  end

  assign full        = is_full;
  assign upd_en      = vld_p1;
  assign upd_index   = index_p1;
  assign upd_taken   = taken_p1;
  assign flush       = flush_p1;
  assign redirect_pc = redirect_p1;
  assign br_count    = br_cnt_p1;
  assign mp_count    = mp_cnt_p1;
  assign underflow   = underflow_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            pr_push, pr_taken, rs_valid, rs_taken;
  logic [1:0]      pr_index;
  logic [31:0]     pr_target, pr_npc;
  logic            full, upd_en, upd_taken, flush, underflow;
  logic [1:0]      upd_index;
  logic [31:0]     redirect_pc;
  logic [CNTW-1:0] br_count, mp_count;

  branch_resolve_unit #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .nRST(nRST),
    .pr_push(pr_push), .pr_taken(pr_taken), .pr_index(pr_index),
    .pr_target(pr_target), .pr_npc(pr_npc),
    .rs_valid(rs_valid), .rs_taken(rs_taken),
    .full(full), .upd_en(upd_en), .upd_index(upd_index), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        taken;
    logic [1:0]  idx;
    logic [31:0] tgt;
    logic [31:0] npc;
  } rec_t;

  rec_t            q[$];
  logic            m_upd_en, m_upd_taken, m_flush, m_underflow;
  logic [1:0]      m_upd_index;
  logic [31:0]     m_redirect;
  logic [CNTW-1:0] m_br, m_mp;
  logic            chk_en = 1'b0;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_upd_en = 0; m_upd_taken = 0; m_flush = 0; m_underflow = 0;
    m_upd_index = 0; m_redirect = 0; m_br = 0; m_mp = 0;
  endtask

  // Next-state of the model from the inputs currently being driven
  task automatic model_step();
    logic popped, mis, was_full;
    rec_t h, n;
    popped = 0; mis = 0;
    was_full = (q.size() == DEPTH);
    m_upd_en = 0; m_flush = 0;
    if (rs_valid) begin
      if (q.size() == 0) begin
        m_underflow = 1;
      end else begin
        h = q.pop_front();
        popped = 1;
        m_upd_en = 1; m_upd_index = h.idx; m_upd_taken = rs_taken;
        if (m_br != {CNTW{1'b1}}) m_br = m_br + 1'b1;
        if (rs_taken != h.taken) begin
          mis = 1; m_flush = 1;
          m_redirect = rs_taken ? h.tgt : h.npc;
          if (m_mp != {CNTW{1'b1}}) m_mp = m_mp + 1'b1;
          q.delete();
        end
      end
    end
    if (pr_push && !mis && (!was_full || popped)) begin
      n.taken = pr_taken; n.idx = pr_index; n.tgt = pr_target; n.npc = pr_npc;
      q.push_back(n);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      check("full", full, q.size() == DEPTH);
      check("upd_en", upd_en, m_upd_en);
      if (m_upd_en) begin
        check("upd_index", upd_index, m_upd_index);
        check("upd_taken", upd_taken, m_upd_taken);
      end
      check("flush", flush, m_flush);
      check("redirect_pc", redirect_pc, m_redirect);
      check("br_count", br_count, m_br);
      check("mp_count", mp_count, m_mp);
      check("underflow", underflow, m_underflow);
    end
  end

  task automatic cyc(input logic p, input logic pt, input logic [1:0] pi, input logic [31:0] tg,
                     input logic [31:0] np, input logic rv, input logic rt);
    @(negedge CLK);
    pr_push = p; pr_taken = pt; pr_index = pi; pr_target = tg; pr_npc = np;
    rs_valid = rv; rs_taken = rt;
    model_step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle_inputs();
    pr_push = 0; pr_taken = 0; pr_index = 0; pr_target = 0; pr_npc = 0;
    rs_valid = 0; rs_taken = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    chk_en = 0; nRST = 0;
    idle_inputs();
    model_clear();
    repeat (2) @(negedge CLK);
    nRST = 1; chk_en = 1;
  endtask

  task automatic push_rand();
    cyc(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic rt;
    nRST = 0;
    idle_inputs();
    model_clear();
    do_reset();

    // Correctly predicted taken branch
    cyc(1, 1, 2'd2, 32'h100, 32'h44, 0, 0);
    cyc(0, 0, 2'd0, 32'h0, 32'h0, 1, 1);
    check("t2_upd_en", upd_en, 1);
    check("t2_upd_index", upd_index, 2);
    check("t2_upd_taken", upd_taken, 1);
    check("t2_flush", flush, 0);
    check("t2_br_count", br_count, 1);

    // Mispredict with a wrong-path push in the same cycle
    cyc(1, 1, 2'd2, 32'h100, 32'h44, 0, 0);
    cyc(1, 1, 2'd1, 32'h200, 32'h48, 1, 0);
    check("t3_flush", flush, 1);
    check("t3_redirect", redirect_pc, 32'h44);
    check("t3_mp_count", mp_count, 1);

    // Fill, overflow push, push+pop while full, wrap
    for (int i = 0; i < 3; i++) push_rand();
    check("t4_not_full_3", full, 0);
    cyc(1, 0, 2'd3, 32'h300, 32'h4c, 0, 0);
    check("t4_full_4", full, 1);
    cyc(1, 1, 2'd0, 32'hDEAD0000, 32'hBEEF0000, 0, 0);
    check("t4_full_drop", full, 1);
    rt = q[0].taken;
    cyc(1, 0, 2'd1, 32'h400, 32'h50, 1, rt);
    check("t4_full_pushpop", full, 1);
    for (int i = 0; i < 8; i++) begin
      rt = q[0].taken;
      cyc(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, 1, rt);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rt = q[0].taken;
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 1, rt);
    end
    check("t4_drained", full, 0);

    // Asynchronous reset with records held and a pulse active
    for (int i = 0; i < DEPTH; i++) push_rand();
    rt = q[0].taken;
    cyc(1, 0, 2'd2, 32'h500, 32'h54, 1, rt);
    check("t1_pre_upd_en", upd_en, 1);
    check("t1_pre_full", full, 1);
    chk_en = 0; nRST = 0;
    #1;
    check("t1_full", full, 0);
    check("t1_upd_en", upd_en, 0);
    check("t1_flush", flush, 0);
    check("t1_br_count", br_count, 0);
    check("t1_mp_count", mp_count, 0);
    check("t1_underflow", underflow, 0);
    check("t1_redirect", redirect_pc, 0);
    idle_inputs();
    model_clear();
    repeat (2) @(negedge CLK);
    nRST = 1; chk_en = 1;

    // Resolve with empty queue
    cyc(0, 0, 2'd0, 32'h0, 32'h0, 1, 1);
    check("t5_underflow", underflow, 1);
    check("t5_upd_en", upd_en, 0);
    check("t5_flush", flush, 0);
    cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 0);
    check("t5_underflow_sticky", underflow, 1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic p, rv;
      p = ($urandom_range(0, 99) < 60);
      if (q.size() > 0) begin
        rv = ($urandom_range(0, 99) < 50);
        rt = ($urandom_range(0, 3) == 0) ? ~q[0].taken : q[0].taken;
      end else begin
        rv = ($urandom_range(0, 99) < 3);
        rt = 1'($urandom_range(0, 1));
      end
      cyc(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, rv, rt);
    end

    // Counter saturation
    do_reset();
    cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 0);
    force dut.br_cnt_p1 = 16'hFFFE;
    force dut.mp_cnt_p1 = 16'hFFFE;
    m_br = 16'hFFFE;
    m_mp = 16'hFFFE;
    #1;
    release dut.br_cnt_p1;
    release dut.mp_cnt_p1;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 2'd3, 32'h600 + i, 32'h60 + i, 0, 0);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 1, 0);
    end
    check("t6_br_count", br_count, 16'hFFFF);
    check("t6_mp_count", mp_count, 16'hFFFF);
    check("t6_redirect", redirect_pc, 32'h62);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
